// File: rtl/ringosc_pkg.sv
// Shared definitions for the ring-oscillator scan controller.
//   state_t              : FSM state encoding used by ringosc_scan_controller
//   DEFAULT_COUNT_WIDTH  : default width of the shared frequency counter
//   DEFAULT_WINDOW_LOG2  : default gate window exponent (window = 2**N CLK cycles)
package ringosc_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 20;
  localparam int DEFAULT_WINDOW_LOG2 = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_COUNT   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_REPORT  = 3'd6
  } state_t;

endpackage

// File: rtl/ringosc_next_select.sv
// Combinational round-robin selector: picks the lowest unmasked oscillator index
// at or after `pointer`, wrapping at NUM_OSC.
//   pointer    in   $clog2(NUM_OSC)  first index to consider
//   osc_mask   in   NUM_OSC          1 = oscillator eligible
//   next_idx   out  $clog2(NUM_OSC)  selected index (0 when none_valid)
//   none_valid out  1                no oscillator eligible
module ringosc_next_select
  import ringosc_pkg::*;
#(
  parameter int NUM_OSC = 4
) (
  input  logic [$clog2(NUM_OSC)-1:0] pointer,
  input  logic [NUM_OSC-1:0]         osc_mask,
  output logic [$clog2(NUM_OSC)-1:0] next_idx,
  output logic                       none_valid
);

  localparam int IDX_W = $clog2(NUM_OSC);

  // pointer + k modulo NUM_OSC; works for non-power-of-two oscillator counts.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_OSC) s = s - NUM_OSC;
    return IDX_W'(s);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    next_idx   = '0;
    none_valid = ~|osc_mask;
    // Walk from the farthest offset down so the nearest eligible index wins.
    for (int k = NUM_OSC - 1; k >= 0; k--) begin
      if (osc_mask[wrap_add(pointer, k)]) next_idx = wrap_add(pointer, k);
    end
  end

endmodule

// File: rtl/ringosc_scan_controller.sv
// Time-multiplexes one shared frequency counter across NUM_OSC ring oscillators.
// Per measurement: enable one oscillator (SETTLE), clear the counter (CLEAR), gate it for
// 2**WINDOW_LOG2 cycles (COUNT), let it quiesce (HOLD), capture (CAPTURE) and present the
// result with a valid/ready handshake (REPORT). Each count is compared with the previous
// count of the same oscillator to flag frequency drops.
//   CLK           in   1                system clock
//   resetn        in   1                asynchronous active-low reset
//   run           in   1                1 = scan continuously
//   osc_mask      in   NUM_OSC          1 = oscillator included in scan
//   osc_enable    out  NUM_OSC          one-hot oscillator enable
//   cnt_clear     out  1                counter synchronous clear
//   cnt_enable    out  1                counter gate
//   cnt_value     in   COUNT_WIDTH      shared counter output
//   result_valid  out  1                result available
//   result_ready  in   1                consumer accepts result
//   result_index  out  $clog2(NUM_OSC)  oscillator measured
//   result_count  out  COUNT_WIDTH      captured count
//   result_drop   out  1                count dropped versus previous of same oscillator
//   busy          out  1                controller not idle
module ringosc_scan_controller
  import ringosc_pkg::*;
#(
  parameter int NUM_OSC        = 4,
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
  parameter int WINDOW_LOG2    = DEFAULT_WINDOW_LOG2,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DROP_THRESHOLD = 5
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       run,
  input  logic [NUM_OSC-1:0]         osc_mask,
  output logic [NUM_OSC-1:0]         osc_enable,
  output logic                       cnt_clear,
  output logic                       cnt_enable,
  input  logic [COUNT_WIDTH-1:0]     cnt_value,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [$clog2(NUM_OSC)-1:0] result_index,
  output logic [COUNT_WIDTH-1:0]     result_count,
  output logic                       result_drop,
  output logic                       busy
);

  localparam int IDX_W   = $clog2(NUM_OSC);
  localparam int PHASE_W = WINDOW_LOG2 + 1;

  localparam logic [PHASE_W-1:0]     SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
  localparam logic [PHASE_W-1:0]     WINDOW_LAST = PHASE_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [COUNT_WIDTH:0]   DROP_THR    = (COUNT_WIDTH + 1)'(DROP_THRESHOLD);

  state_t                  state;
  logic [PHASE_W-1:0]      phase;      // shared down-counter for every timed state
  logic [IDX_W-1:0]        idx;        // oscillator under measurement
  logic [IDX_W-1:0]        pointer;    // where the next round-robin search starts
  logic [IDX_W-1:0]        idx_inc;
  logic [IDX_W-1:0]        sel_ptr;
  logic [IDX_W-1:0]        next_idx;
  logic                    none_valid;
  logic [NUM_OSC-1:0]      sel_onehot;
  logic                    drop_now;
  logic                    capture_en;

  logic [COUNT_WIDTH-1:0]  prev [NUM_OSC];
  logic [NUM_OSC-1:0]      prev_valid;

  assign idx_inc = (int'(idx) == NUM_OSC - 1) ? '0 : idx + 1'b1;

  // On acceptance in REPORT the pointer register has not advanced yet, so search from
  // idx+1 directly; that lets the next SETTLE start on the cycle after acceptance.
  assign sel_ptr = (state == ST_REPORT) ? idx_inc : pointer;

  ringosc_next_select #(
    .NUM_OSC (NUM_OSC)
  ) u_next_select (
    .pointer    (sel_ptr),
    .osc_mask   (osc_mask),
    .next_idx   (next_idx),
    .none_valid (none_valid)
  );

  assign sel_onehot = NUM_OSC'(1) << next_idx;

  // One extra bit keeps count + threshold from wrapping.
  assign drop_now   = prev_valid[idx] && ({1'b0, prev[idx]} > ({1'b0, cnt_value} + DROP_THR));
  assign capture_en = (state == ST_CAPTURE) && run;

  assign busy = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      phase        <= '0;
      idx          <= '0;
      pointer      <= '0;
      osc_enable   <= '0;
      cnt_clear    <= 1'b0;
      cnt_enable   <= 1'b0;
      result_valid <= 1'b0;
      result_index <= '0;
      result_count <= '0;
      result_drop  <= 1'b0;
      prev_valid   <= '0;
    end else if (!run && (state inside {ST_SETTLE, ST_CLEAR, ST_COUNT, ST_HOLD, ST_CAPTURE})) begin
      // Abort: pointer stays put so the next run re-measures the same oscillator.
      state      <= ST_IDLE;
      osc_enable <= '0;
      cnt_clear  <= 1'b0;
      cnt_enable <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run && !none_valid) begin
            idx        <= next_idx;
            osc_enable <= sel_onehot;
            phase      <= SETTLE_LAST;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (phase != '0) phase <= phase - 1'b1;
          else begin
            cnt_clear <= 1'b1;
            phase     <= SETTLE_LAST;
            state     <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          if (phase != '0) phase <= phase - 1'b1;
          else begin
            cnt_clear  <= 1'b0;
            cnt_enable <= 1'b1;
            phase      <= WINDOW_LAST;
            state      <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (phase != '0) phase <= phase - 1'b1;
          else begin
            cnt_enable <= 1'b0;
            phase      <= SETTLE_LAST;
            state      <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // The counter is static once its gate has been low for a few cycles,
          // so cnt_value can be sampled directly without a synchroniser.
          if (phase != '0) phase <= phase - 1'b1;
          else             state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          result_count    <= cnt_value;
          result_index    <= idx;
          result_drop     <= drop_now;
          result_valid    <= 1'b1;
          prev_valid[idx] <= 1'b1;
          osc_enable      <= '0;
          state           <= ST_REPORT;
        end

        ST_REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            pointer      <= idx_inc;
            if (run && !none_valid) begin
              idx        <= next_idx;
              osc_enable <= sel_onehot;
              phase      <= SETTLE_LAST;
              state      <= ST_SETTLE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the history array has no reset; prev_valid qualifies every read, so its contents never matter before the first write.
  always_ff @(posedge CLK) begin
    if (capture_en) prev[idx] <= cnt_value;
  end

endmodule
